// File: rtl/lsu_store_unit.sv
`timescale 1ns/1ps
// Store unit: forms store addresses, traps misaligned word stores, holds stores in
// program order until committed, then drains them one at a time to memory.
module lsu_store_unit #(
    parameter int WORD_SIZE_P  = 16,
    parameter int NUM_ARCH_REG = 8,
    parameter int SB_DEPTH_P   = 4,
    parameter int TAG_W_P      = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    // Handshakes: a store transfers on a rising edge with st_v_i and st_ready_o both high;
    // a memory write completes on a rising edge with mem_v_o and mem_ack_i both high, and
    // mem_addr_o/mem_data_o/mem_byte_o stay stable from mem_v_o rising until that edge.
    input  logic                          st_v_i,
    output logic                          st_ready_o,
    input  logic [WORD_SIZE_P-1:0]        st_base_i,
    input  logic [WORD_SIZE_P-1:0]        st_data_i,
    input  logic [WORD_SIZE_P-1:0]        st_packed_i,
    input  logic                          st_byte_i,
    input  logic [TAG_W_P-1:0]            st_tag_i,
    input  logic                          commit_i,
    input  logic                          flush_i,
    output logic                          exc_v_o,
    output logic [TAG_W_P-1:0]            exc_tag_o,
    output logic                          mem_v_o,
    output logic [WORD_SIZE_P-1:0]        mem_addr_o,
    output logic [WORD_SIZE_P-1:0]        mem_data_o,
    output logic                          mem_byte_o,
    input  logic                          mem_ack_i,
    output logic [$clog2(SB_DEPTH_P):0]   count_o,
    output logic                          empty_o,
    output logic                          drain_state_o
);

    localparam int PTR_W     = $clog2(SB_DEPTH_P);
    localparam int CNT_W     = PTR_W + 1;
    localparam int REG_IDX_W = $clog2(NUM_ARCH_REG);

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    drain_state_e state_q;

    logic [WORD_SIZE_P-1:0] sb_addr_q    [SB_DEPTH_P];
    logic [WORD_SIZE_P-1:0] sb_data_q    [SB_DEPTH_P];
    logic                   sb_is_byte_q [SB_DEPTH_P];

    logic [PTR_W-1:0] head_q, tail_q, head_next, tail_next;
    logic [CNT_W-1:0] count_q, count_next;
    // Commits are in order, so committed entries are always the oldest ncommit_q ones.
    logic [CNT_W-1:0] ncommit_q, ncommit_next;

    logic [WORD_SIZE_P-1:0] offset_ext, offset, st_addr;
    logic misaligned, xfer, enq, pop, do_commit;

    // The source-register index shares the packed field but is consumed elsewhere.
    logic [REG_IDX_W-1:0] unused_src2_idx;
    logic                 unused_packed;
    assign unused_src2_idx = st_packed_i[REG_IDX_W-1:0];
    assign unused_packed   = ^st_packed_i;

    assign offset_ext = {{(WORD_SIZE_P-5){st_packed_i[15]}}, st_packed_i[15:11]};
    assign offset     = st_byte_i ? offset_ext : {offset_ext[WORD_SIZE_P-2:0], 1'b0};
    assign st_addr    = st_base_i + offset;
    assign misaligned = !st_byte_i && st_addr[0];

    assign st_ready_o = (count_q < CNT_W'(SB_DEPTH_P)) && !flush_i;
    assign xfer       = st_v_i && st_ready_o;
    assign enq        = xfer && !misaligned;
    assign pop        = (state_q == DRAIN_REQ) && mem_ack_i;
    assign do_commit  = commit_i && (ncommit_q < count_q);

    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign drain_state_o = state_q;

    always_comb begin
        ncommit_next = ncommit_q + CNT_W'(do_commit) - CNT_W'(pop);
        head_next    = head_q + PTR_W'(pop);
        tail_next    = tail_q + PTR_W'(enq);
        count_next   = count_q + CNT_W'(enq) - CNT_W'(pop);
        // Flush never coincides with an enqueue because st_ready_o is low during it.
        if (flush_i) begin
            count_next = ncommit_next;
            tail_next  = head_next + ncommit_next[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ncommit_q <= '0;
        end else begin
            head_q    <= head_next;
            tail_q    <= tail_next;
            count_q   <= count_next;
            ncommit_q <= ncommit_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            sb_addr_q[tail_q]    <= st_addr;
            sb_data_q[tail_q]    <= st_data_i;
            sb_is_byte_q[tail_q] <= st_byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            exc_v_o   <= 1'b0;
            exc_tag_o <= '0;
        end else begin
            exc_v_o <= xfer && misaligned;
            if (xfer && misaligned) begin
                exc_tag_o <= st_tag_i;
            end
        end
    end

    // The head entry cannot move while a request is outstanding, so latching it once is safe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= DRAIN_IDLE;
            mem_v_o    <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_byte_o <= 1'b0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (ncommit_q != '0) begin
                        state_q    <= DRAIN_REQ;
                        mem_v_o    <= 1'b1;
                        mem_addr_o <= sb_addr_q[head_q];
                        mem_data_o <= sb_data_q[head_q];
                        mem_byte_o <= sb_is_byte_q[head_q];
                    end
                end
                DRAIN_REQ: begin
                    if (mem_ack_i) begin
                        state_q <= DRAIN_IDLE;
                        mem_v_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DRAIN_IDLE;
                    mem_v_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_store_unit.sv
`timescale 1ns/1ps
// Bench for lsu_store_unit: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the store buffer.
module tb_lsu_store_unit;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n_i;
    logic             st_v_i, st_ready_o, st_byte_i, commit_i, flush_i;
    logic [W-1:0]     st_base_i, st_data_i, st_packed_i;
    logic [TAG_W-1:0] st_tag_i, exc_tag_o;
    logic             exc_v_o, mem_v_o, mem_byte_o, mem_ack_i, empty_o, drain_state_o;
    logic [W-1:0]     mem_addr_o, mem_data_o;
    logic [2:0]       count_o;

    lsu_store_unit #(.WORD_SIZE_P(W), .NUM_ARCH_REG(8), .SB_DEPTH_P(DEPTH), .TAG_W_P(TAG_W)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .st_v_i(st_v_i), .st_ready_o(st_ready_o), .st_base_i(st_base_i), .st_data_i(st_data_i),
        .st_packed_i(st_packed_i), .st_byte_i(st_byte_i), .st_tag_i(st_tag_i),
        .commit_i(commit_i), .flush_i(flush_i), .exc_v_o(exc_v_o), .exc_tag_o(exc_tag_o),
        .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_byte_o(mem_byte_o), .mem_ack_i(mem_ack_i), .count_o(count_o),
        .empty_o(empty_o), .drain_state_o(drain_state_o)
    );

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic         is_byte;
        logic         committed;
    } ent_t;

    ent_t             ent_q[$];
    logic             exp_exc;
    logic [TAG_W-1:0] exp_tag;
    logic             prev_pop;
    int               idle_wait;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_addr(input logic [W-1:0] base, input logic [W-1:0] pk,
                                                input logic is_byte);
        int off;
        int sum;
        off = int'(pk[15:11]);
        if (off >= 16) off = off - 32;
        if (!is_byte) off = off * 2;
        sum = int'(base) + off;
        return W'(sum & 32'hFFFF);
    endfunction

    // Checks the current cycle's outputs, then advances the model across the coming edge.
    task automatic compare();
        int           n;
        logic         xfer, mis, pop, head_c;
        logic [W-1:0] a;
        ent_t         keep[$];
        ent_t         e;
        n = ent_q.size();
        check("count", 32'(count_o), n);
        check("empty", 32'(empty_o), 32'(n == 0));
        check("ready", 32'(st_ready_o), 32'((n < DEPTH) && !flush_i));
        check("exc_v", 32'(exc_v_o), 32'(exp_exc));
        if (exp_exc) check("exc_tag", 32'(exc_tag_o), 32'(exp_tag));
        if (prev_pop) check("bubble", 32'(mem_v_o), 0);
        head_c = (n > 0) && ent_q[0].committed;
        if (mem_v_o) begin
            check("mem_head_committed", 32'(head_c), 1);
            if (head_c) begin
                check("mem_addr", 32'(mem_addr_o), 32'(ent_q[0].addr));
                check("mem_data", 32'(mem_data_o), 32'(ent_q[0].data));
                check("mem_byte", 32'(mem_byte_o), 32'(ent_q[0].is_byte));
            end
        end
        if (head_c && !mem_v_o) begin
            idle_wait++;
            check("drain_start", 32'(idle_wait <= 1), 1);
        end else begin
            idle_wait = 0;
        end

        xfer = st_v_i && (n < DEPTH) && !flush_i;
        a    = model_addr(st_base_i, st_packed_i, st_byte_i);
        mis  = !st_byte_i && a[0];
        pop  = mem_v_o && mem_ack_i;
        if (commit_i) begin
            for (int i = 0; i < n; i++) begin
                if (!ent_q[i].committed) begin
                    ent_q[i].committed = 1'b1;
                    break;
                end
            end
        end
        if (pop && ent_q.size() > 0) void'(ent_q.pop_front());
        if (flush_i) begin
            foreach (ent_q[i]) if (ent_q[i].committed) keep.push_back(ent_q[i]);
            ent_q = keep;
        end
        if (xfer && !mis) begin
            e.addr = a; e.data = st_data_i; e.is_byte = st_byte_i; e.committed = 1'b0;
            ent_q.push_back(e);
        end
        exp_exc  = xfer && mis;
        exp_tag  = st_tag_i;
        prev_pop = pop;
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset_n_i) begin
            compare();
        end else begin
            ent_q.delete();
            exp_exc   = 1'b0;
            prev_pop  = 1'b0;
            idle_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] base, input logic [W-1:0] data, input logic [W-1:0] pk,
                       input logic is_byte, input logic [TAG_W-1:0] tag);
        st_v_i = 1'b1; st_base_i = base; st_data_i = data; st_packed_i = pk;
        st_byte_i = is_byte; st_tag_i = tag;
        tick();
        st_v_i = 1'b0;
    endtask

    task automatic wait_mem(input string name);
        for (int i = 0; i < 10 && !mem_v_o; i++) tick();
        check(name, 32'(mem_v_o), 1);
    endtask

    task automatic drain_all();
        st_v_i = 1'b0; flush_i = 1'b0; commit_i = 1'b1; mem_ack_i = 1'b1;
        for (int i = 0; i < 100 && !empty_o; i++) tick();
        commit_i = 1'b0; mem_ack_i = 1'b0;
        check("drain_empty", 32'(empty_o), 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n_i = 1'b0; st_v_i = 1'b0; st_base_i = '0; st_data_i = '0; st_packed_i = '0;
        st_byte_i = 1'b0; st_tag_i = '0; commit_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
        exp_exc = 1'b0; exp_tag = '0; prev_pop = 1'b0; idle_wait = 0;

        check("pin_addr_neg",  32'(model_addr(16'h1000, 16'hF800, 1'b0)), 32'h0FFE);
        check("pin_addr_byte", 32'(model_addr(16'h0003, 16'h7800, 1'b1)), 32'h0012);
        check("pin_addr_wrap", 32'(model_addr(16'hFFFE, 16'h0800, 1'b0)), 32'h0000);

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_mem_v", 32'(mem_v_o), 0);
        check("rst_exc_v", 32'(exc_v_o), 0);
        reset_n_i = 1'b1;
        tick();
        check("ready_after_reset", 32'(st_ready_o), 1);

        // Negative word offset
        put(16'h1000, 16'hABCD, 16'hF800, 1'b0, 4'd1);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        wait_mem("t1_mem_v");
        check("t1_addr", 32'(mem_addr_o), 32'h0FFE);
        check("t1_byte", 32'(mem_byte_o), 0);
        mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
        tick();
        check("t1_empty", 32'(empty_o), 1);

        // Byte store with positive offset, then a misaligned word store
        put(16'h0003, 16'h0055, 16'h7800, 1'b1, 4'd2);
        check("t2_count", 32'(count_o), 1);
        check("t2_no_exc", 32'(exc_v_o), 0);
        put(16'h0001, 16'h1234, 16'h0000, 1'b0, 4'd5);
        check("t2_exc_v", 32'(exc_v_o), 1);
        check("t2_exc_tag", 32'(exc_tag_o), 5);
        check("t2_count_same", 32'(count_o), 1);
        tick();
        check("t2_exc_pulse", 32'(exc_v_o), 0);
        drain_all();

        // Address wrap-around
        put(16'hFFFE, 16'h7777, 16'h0800, 1'b0, 4'd3);
        check("t3_no_exc", 32'(exc_v_o), 0);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        wait_mem("t3_mem_v");
        check("t3_addr", 32'(mem_addr_o), 32'h0000);
        drain_all();

        // Fill the buffer, drain one
        for (int k = 0; k < DEPTH; k++) put(W'(k * 16), W'($urandom_range(0, 65535)), 16'h0000, 1'b1, TAG_W'(k));
        check("t4_full_count", 32'(count_o), 4);
        check("t4_full_ready", 32'(st_ready_o), 0);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        wait_mem("t4_mem_v");
        mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
        check("t4_count3", 32'(count_o), 3);
        check("t4_ready", 32'(st_ready_o), 1);
        drain_all();

        // Flush with committed entries, then commit and flush together
        for (int k = 0; k < DEPTH; k++) put(W'(16'h0200 + k * 2), W'(k + 1), 16'h0000, 1'b0, TAG_W'(k));
        commit_i = 1'b1; tick(); tick(); commit_i = 1'b0;
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        check("t5_flush_count", 32'(count_o), 2);
        drain_all();
        put(16'h0300, 16'h00AA, 16'h0000, 1'b0, 4'd7);
        put(16'h0302, 16'h00BB, 16'h0000, 1'b0, 4'd8);
        commit_i = 1'b1; flush_i = 1'b1; tick(); commit_i = 1'b0; flush_i = 1'b0;
        check("t5_commit_flush_count", 32'(count_o), 1);
        drain_all();

        // Reset during an outstanding request
        put(16'h0400, 16'h00CC, 16'h0000, 1'b0, 4'd9);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        wait_mem("t6_mem_v");
        #2 reset_n_i = 1'b0;
        #1;
        check("t6_mem_v_async", 32'(mem_v_o), 0);
        check("t6_count_async", 32'(count_o), 0);
        check("t6_empty_async", 32'(empty_o), 1);
        mem_ack_i = 1'b1;
        tick();
        reset_n_i = 1'b1;
        repeat (3) tick();
        mem_ack_i = 1'b0;
        check("t6_ready", 32'(st_ready_o), 1);
        check("t6_mem_v_after", 32'(mem_v_o), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            st_v_i      = ($urandom_range(0, 1) == 1);
            st_base_i   = W'($urandom_range(0, 65535));
            st_data_i   = W'($urandom_range(0, 65535));
            st_packed_i = W'($urandom_range(0, 65535));
            st_byte_i   = ($urandom_range(0, 1) == 1);
            st_tag_i    = TAG_W'($urandom_range(0, 15));
            commit_i    = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            mem_ack_i   = ($urandom_range(0, 1) == 1);
            tick();
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_store_unit.md
LSU_STORE_UNIT -- requirements
Module: lsu_store_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE_P, default 16, the datapath width.
REQ-002 SHALL have parameter NUM_ARCH_REG, default 8; the register index occupies the low $clog2(NUM_ARCH_REG) bits of the packed field.
REQ-003 SHALL have parameter SB_DEPTH_P, default 4, the number of store buffer entries (power of two).
REQ-004 SHALL have parameter TAG_W_P, default 4, the width of the instruction tag.
REQ-005 clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 st_v_i / st_ready_o  in/out  1 each  store issue handshake; transfer when both are high.
REQ-008 st_base_i  in  WORD_SIZE_P  base register value.
REQ-009 st_data_i  in  WORD_SIZE_P  store data.
REQ-010 st_packed_i  in  WORD_SIZE_P  packed field: [15:11] = 5-bit offset, low bits = src2 index (index ignored here).
REQ-011 st_byte_i  in  1  1 = byte store, 0 = word store.
REQ-012 st_tag_i  in  TAG_W_P  instruction tag.
REQ-013 commit_i  in  1  commit the oldest uncommitted buffered store.
REQ-014 flush_i  in  1  discard all uncommitted entries.
REQ-015 exc_v_o, exc_tag_o  out  1, TAG_W_P  misaligned-store exception pulse and its tag.
REQ-016 mem_v_o  out  1; mem_addr_o, mem_data_o  out  WORD_SIZE_P; mem_byte_o  out  1; mem_ack_i  in  1  memory write handshake.
REQ-017 count_o  out  $clog2(SB_DEPTH_P)+1  current buffer occupancy.
REQ-018 empty_o  out  1  high when count_o is 0.

Function
REQ-019 SHALL compute offset = sign-extend(st_packed_i[15:11]): shifted left by 1 for word stores, unshifted for byte stores.
REQ-020 SHALL compute addr = st_base_i + offset modulo 2^WORD_SIZE_P (wrap-around, no carry out).
REQ-021 SHALL drive st_ready_o = (count < SB_DEPTH_P) && !flush_i, combinationally.
REQ-022 On transfer of a word store with addr[0]=1: SHALL NOT enqueue; SHALL pulse exc_v_o for exactly one cycle on the next cycle, with exc_tag_o = st_tag_i.
REQ-023 Any other transfer SHALL enqueue {addr, data, byte, committed=0} at the tail; the new entry is visible in count_o on the next cycle.
REQ-024 commit_i SHALL set committed on the oldest uncommitted entry; commit_i with no uncommitted entry is ignored.
REQ-025 flush_i SHALL remove all uncommitted entries in one cycle; committed entries and an in-flight request are preserved.
REQ-026 When commit_i and flush_i are high in the same cycle, the commit SHALL apply first; that entry survives the flush.
REQ-027 Drain FSM, IDLE: if the head entry is committed, go to REQ on the next cycle.
REQ-028 Drain FSM, REQ: assert mem_v_o, with mem_addr_o/mem_data_o/mem_byte_o driven from the head entry and held stable until mem_ack_i.
REQ-029 Drain FSM, REQ with mem_ack_i: pop the head and return to IDLE, giving one bubble cycle minimum per store.
REQ-030 mem_ack_i while in IDLE SHALL be ignored.
REQ-031 Enqueue and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo SB_DEPTH_P.
REQ-032 Stores SHALL drain to memory in strict program (enqueue) order.

Reset
REQ-033 While reset_n_i is low, SHALL immediately clear all pointers, count and committed bits, force the FSM to IDLE, and drive mem_v_o=0, exc_v_o=0, empty_o=1, count_o=0.
REQ-034 After reset is released, st_ready_o SHALL be 1 (when flush_i is low); an assertion of reset in the middle of REQ abandons the request with no pop.

Verification
REQ-035 Word store, base 0x1000, packed 0xF800 (offset -1), commit, ack -> mem_addr_o=0x0FFE, mem_byte_o=0, then empty_o=1.
REQ-036 Byte store, base 0x0003, packed 0x7800 (offset +15) -> addr 0x0012, no exception; word store, base 0x0001, packed 0x0000, tag 5 -> exc_v_o one cycle with exc_tag_o=5, count_o unchanged.
REQ-037 Word store, base 0xFFFE, packed 0x0800 (offset +1) -> addr 0x0000 (wrap-around), no exception.
REQ-038 Enqueue 4 stores -> count_o=4 and st_ready_o=0; commit 1, ack -> count_o=3 and st_ready_o=1; remaining drain in order.
REQ-039 Four entries with 2 committed, flush_i -> count_o=2 next cycle; commit_i and flush_i together with 2 uncommitted -> count_o=1 uncommitted dropped, 1 committed kept.
REQ-040 reset_n_i low while mem_v_o=1 -> mem_v_o=0 and count_o=0 in the same cycle without a clock edge; later ack ignored.
